// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, default widths, queue entry.
package if_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_QDEPTH = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] inst;
  } q_entry_t;

  // Instructions are word aligned; any set low bit is a misaligned fetch.
  function automatic logic pc_aligned(input logic [1:0] pc_lsb);
    return (pc_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/ack bus plus the decode-side valid/ready instruction bus.
interface if_fetch_if
  import if_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  logic              inst_valid;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_ack, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_ack, imem_rdata, inst_ready
  );

endinterface

// File: rtl/if_queue.sv
// Two-entry {pc, inst} FIFO with synchronous clear; head fields come straight from storage.
// When empty the head shows the last entry presented, so outputs hold after a pop or clear.
module if_queue
  import if_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_pc_i,
  input  logic [DATA_W-1:0] push_inst_i,
  input  logic              pop_i,
  input  logic              clear_i,
  output logic [1:0]        count_o,
  output logic [ADDR_W-1:0] head_pc_o,
  output logic [DATA_W-1:0] head_inst_o
);

  logic [ADDR_W-1:0] pc_q   [2];
  logic [DATA_W-1:0] inst_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_push, do_pop, head_sel;

  assign do_push = push_i && !clear_i;
  assign do_pop  = pop_i && !clear_i && (count_q != 2'd0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      // Park both pointers one past the current head so the empty view keeps showing it.
      rd_ptr_d = ~rd_ptr_q;
      wr_ptr_d = ~rd_ptr_q;
      count_d  = 2'd0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) begin
        pc_q[wr_ptr_q]   <= push_pc_i;
        inst_q[wr_ptr_q] <= push_inst_i;
      end
    end
  end

  assign head_sel    = (count_q == 2'd0) ? ~rd_ptr_q : rd_ptr_q;
  assign head_pc_o   = pc_q[head_sel];
  assign head_inst_o = inst_q[head_sel];
  assign count_o     = count_q;

endmodule

// File: rtl/if_fetch.sv
// Fetch stage: one outstanding imem request, results queued 2-deep toward decode; PC advances
// on ack or flush. Zero-wait memory yields one instruction per two cycles, visible the cycle after ack.
module if_fetch
  import if_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int QDEPTH = DEF_QDEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_ena,
  input  logic              flush,
  output logic              fault,
  if_fetch_if.master        bus
);

  localparam logic [1:0] QFULL = 2'(QDEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        q_count;
  logic              q_push, q_pop;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pc_ena  = 1'b0;
    q_push  = 1'b0;
    if (flush) begin
      // Redirect wins; an in-flight request must still be retired, its data thrown away.
      pc_ena = 1'b1;
      case (state_q)
        S_WAIT, S_DROP: state_d = bus.imem_ack ? S_IDLE : S_DROP;
        default:        state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (q_count < QFULL) begin
            if (pc_aligned(pc_in[1:0])) begin
              addr_d  = pc_in;
              state_d = S_WAIT;
            end else begin
              state_d = S_FAULT;
            end
          end
        end
        S_WAIT: begin
          if (bus.imem_ack) begin
            q_push  = 1'b1;
            pc_ena  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_DROP: begin
          if (bus.imem_ack) state_d = S_IDLE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.imem_req  = (state_q == S_WAIT) || (state_q == S_DROP);
  assign bus.imem_addr = addr_q;
  assign fault         = (state_q == S_FAULT);

  assign bus.inst_valid = (q_count != 2'd0);
  assign q_pop          = bus.inst_valid && bus.inst_ready;

  if_queue #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (q_push),
    .push_pc_i   (addr_q),
    .push_inst_i (bus.imem_rdata),
    .pop_i       (q_pop),
    .clear_i     (flush),
    .count_o     (q_count),
    .head_pc_o   (bus.inst_pc),
    .head_inst_o (bus.inst_data)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: PC-register and memory models, per-cycle vector table, hand sequences, data scoreboard.
module tb_if_fetch;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_q;
  logic [31:0] pc_start = 32'h0;
  logic [31:0] flush_tgt = 32'h0;
  logic        pc_ena;
  logic        flush = 1'b0;
  logic        fault;
  logic        ack_en = 1'b1;
  int          ack_lat = 0;
  logic        ovr = 1'b0;
  int          cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  if_fetch #(.ADDR_W(32), .DATA_W(32), .QDEPTH(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pc_in  (pc_q),
    .pc_ena (pc_ena),
    .flush  (flush),
    .fault  (fault),
    .bus    (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h20080005 : (a ^ 32'h5A5A0000);
  endfunction

  // PC register: loads pc+4 or the redirect target when enabled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pc_q <= pc_start;
    else if (pc_ena) pc_q <= flush ? flush_tgt : pc_q + 32'd4;
  end

  // Memory: acks after ack_lat cycles of waiting.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             cnt <= 0;
    else if (bus.imem_req && !bus.imem_ack) cnt <= cnt + 1;
    else                                    cnt <= 0;
  end
  assign bus.imem_ack   = ack_en && bus.imem_req && (cnt >= ack_lat);
  assign bus.imem_rdata = ovr ? 32'hDEADBEEF : mem_word(bus.imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [31:0] start);
    @(posedge clk);
    #1;
    pc_start = start;
    flush    = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          req;
    logic [31:0] addr;
    bit          pena;
    bit          vld;
    logic [31:0] ipc;
  } vec_t;

  vec_t     vt[16];
  q_entry_t exp_q[$];
  bit       dropped = 1'b0;

  initial begin
    bus.inst_ready = 1'b0;

    // Scoreboard: words accepted from memory must leave the queue in order, unchanged.
    fork
      forever begin
        q_entry_t e;
        @(negedge clk);
        if (!rst_n) begin
          exp_q.delete();
          dropped = 1'b0;
        end else if (flush) begin
          exp_q.delete();
          if (bus.imem_ack)       dropped = 1'b0;
          else if (bus.imem_req)  dropped = 1'b1;
        end else begin
          if (bus.inst_valid && bus.inst_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL sb_pop: got pc %h with nothing expected", bus.inst_pc);
            end else begin
              e = exp_q.pop_front();
              chk("sb_pc", bus.inst_pc, e.pc);
              chk("sb_data", bus.inst_data, e.inst);
            end
          end
          if (bus.imem_ack) begin
            if (dropped) dropped = 1'b0;
            else begin
              e.pc   = bus.imem_addr;
              e.inst = bus.imem_rdata;
              exp_q.push_back(e);
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    smp();
    chk("rst_req",   {31'b0, bus.imem_req},   32'h0);
    chk("rst_addr",  bus.imem_addr,           32'h0);
    chk("rst_pena",  {31'b0, pc_ena},         32'h0);
    chk("rst_valid", {31'b0, bus.inst_valid}, 32'h0);
    chk("rst_data",  bus.inst_data,           32'h0);
    chk("rst_pc",    bus.inst_pc,             32'h0);
    chk("rst_fault", {31'b0, fault},          32'h0);

    //          rst  rdy  req addr   pena vld ipc
    vt[0]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};  // zero-wait fetch
    vt[1]  = '{1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 32'h4, 1'b1, 1'b0, 32'h0};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 32'h4, 1'b0, 1'b1, 32'h4};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 32'h4};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};  // backpressure
    vt[7]  = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 32'h4, 1'b1, 1'b1, 32'h0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 32'h4, 1'b0, 1'b1, 32'h0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 32'h4, 1'b0, 1'b1, 32'h0};
    vt[12] = '{1'b0, 1'b1, 1'b0, 32'h4, 1'b0, 1'b1, 32'h0};  // full: pop does not issue
    vt[13] = '{1'b0, 1'b1, 1'b0, 32'h4, 1'b0, 1'b1, 32'h4};
    vt[14] = '{1'b0, 1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 32'h4};
    vt[15] = '{1'b0, 1'b1, 1'b0, 32'h8, 1'b0, 1'b1, 32'h8};

    for (int i = 0; i < 16; i++) begin
      if (vt[i].rst) do_reset(32'h0);
      else           cyc();
      bus.inst_ready = vt[i].rdy;
      smp();
      chk($sformatf("vec%0d_req", i),   {31'b0, bus.imem_req},   {31'b0, vt[i].req});
      chk($sformatf("vec%0d_addr", i),  bus.imem_addr,           vt[i].addr);
      chk($sformatf("vec%0d_pena", i),  {31'b0, pc_ena},         {31'b0, vt[i].pena});
      chk($sformatf("vec%0d_valid", i), {31'b0, bus.inst_valid}, {31'b0, vt[i].vld});
      chk($sformatf("vec%0d_ipc", i),   bus.inst_pc,             vt[i].ipc);
    end

    // Wait states: request held 4 cycles, one pc_ena in the ack cycle
    ack_lat = 3;
    do_reset(32'h0);
    bus.inst_ready = 1'b1;
    smp();
    chk("ws_c0_req", {31'b0, bus.imem_req}, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      smp();
      chk($sformatf("ws_c%0d_req", k),  {31'b0, bus.imem_req}, 32'h1);
      chk($sformatf("ws_c%0d_addr", k), bus.imem_addr,         32'h0);
      chk($sformatf("ws_c%0d_pena", k), {31'b0, pc_ena},       (k == 4) ? 32'h1 : 32'h0);
    end
    cyc();
    smp();
    chk("ws_c5_valid", {31'b0, bus.inst_valid}, 32'h1);
    chk("ws_c5_pc",    bus.inst_pc,             32'h0);
    chk("ws_c5_pena",  {31'b0, pc_ena},         32'h0);

    // Flush with request outstanding; the late DEADBEEF must be dropped
    ack_lat = 0;
    ack_en  = 1'b0;
    do_reset(32'h0);
    bus.inst_ready = 1'b1;
    cyc();
    smp();
    chk("fl_c1_req",  {31'b0, bus.imem_req}, 32'h1);
    chk("fl_c1_pena", {31'b0, pc_ena},       32'h0);
    cyc();
    flush     = 1'b1;
    flush_tgt = 32'h100;
    smp();
    chk("fl_c2_pena", {31'b0, pc_ena}, 32'h1);
    cyc();
    flush = 1'b0;
    smp();
    chk("fl_c3_req",   {31'b0, bus.imem_req},   32'h1);
    chk("fl_c3_addr",  bus.imem_addr,           32'h0);
    chk("fl_c3_pena",  {31'b0, pc_ena},         32'h0);
    chk("fl_c3_valid", {31'b0, bus.inst_valid}, 32'h0);
    cyc();
    ack_en = 1'b1;
    ovr    = 1'b1;
    smp();
    chk("fl_c4_pena", {31'b0, pc_ena}, 32'h0);
    cyc();
    ovr = 1'b0;
    smp();
    chk("fl_c5_req",    {31'b0, bus.imem_req},   32'h0);
    chk("fl_c5_valid",  {31'b0, bus.inst_valid}, 32'h0);
    chk("fl_c5_nodead", {31'b0, bus.inst_data == 32'hDEADBEEF}, 32'h0);
    cyc();
    smp();
    chk("fl_c6_req",  {31'b0, bus.imem_req}, 32'h1);
    chk("fl_c6_addr", bus.imem_addr,         32'h100);
    chk("fl_c6_pena", {31'b0, pc_ena},       32'h1);
    cyc();
    smp();
    chk("fl_c7_valid",  {31'b0, bus.inst_valid}, 32'h1);
    chk("fl_c7_pc",     bus.inst_pc,             32'h100);
    chk("fl_c7_data",   bus.inst_data,           mem_word(32'h100));

    // Misaligned PC fault, cleared by flush
    do_reset(32'h6);
    smp();
    chk("mis_c0_fault", {31'b0, fault}, 32'h0);
    cyc();
    smp();
    chk("mis_c1_fault", {31'b0, fault},        32'h1);
    chk("mis_c1_req",   {31'b0, bus.imem_req}, 32'h0);
    chk("mis_c1_pena",  {31'b0, pc_ena},       32'h0);
    cyc();
    flush     = 1'b1;
    flush_tgt = 32'h10;
    smp();
    chk("mis_c2_pena",  {31'b0, pc_ena}, 32'h1);
    chk("mis_c2_fault", {31'b0, fault},  32'h1);
    cyc();
    flush = 1'b0;
    smp();
    chk("mis_c3_fault", {31'b0, fault},        32'h0);
    chk("mis_c3_req",   {31'b0, bus.imem_req}, 32'h0);
    cyc();
    smp();
    chk("mis_c4_req",  {31'b0, bus.imem_req}, 32'h1);
    chk("mis_c4_addr", bus.imem_addr,         32'h10);
    cyc();
    smp();
    chk("mis_c5_pc", bus.inst_pc, 32'h10);

    // Async reset mid-WAIT with one entry queued
    do_reset(32'h0);
    bus.inst_ready = 1'b0;
    cyc();
    cyc();
    ack_en = 1'b0;
    cyc();
    smp();
    chk("ar_pre_req",   {31'b0, bus.imem_req},   32'h1);
    chk("ar_pre_addr",  bus.imem_addr,           32'h4);
    chk("ar_pre_valid", {31'b0, bus.inst_valid}, 32'h1);
    #2;
    pc_start = 32'h20;
    rst_n    = 1'b0;
    #1;
    chk("ar_req",   {31'b0, bus.imem_req},   32'h0);
    chk("ar_valid", {31'b0, bus.inst_valid}, 32'h0);
    chk("ar_fault", {31'b0, fault},          32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    ack_en = 1'b1;
    smp();
    chk("ar_c0_req", {31'b0, bus.imem_req}, 32'h0);
    cyc();
    smp();
    chk("ar_c1_req",  {31'b0, bus.imem_req}, 32'h1);
    chk("ar_c1_addr", bus.imem_addr,         32'h20);

    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC and fetches one instruction word from instruction memory over a req/ack handshake.
- Buffers fetched {pc, instruction} pairs in a 2-entry queue toward decode.
- Drives the PC register's enable so the PC advances only when a fetch completes or a redirect occurs.

Parameters:
- ADDR_W, 32, PC and memory address width
- DATA_W, 32, instruction word width
- QDEPTH, 2, instruction queue depth (fixed at 2; other values unsupported)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pc_in  in  ADDR_W  current PC from PC register output
- pc_ena  out  1  enable to PC register; PC register loads its data input at the edge where this is 1
- flush  in  1  branch/jump redirect; external next-PC mux selects target this cycle
- imem_req  out  1  fetch request, held until acknowledged
- imem_addr  out  ADDR_W  fetch address, stable while imem_req=1
- imem_ack  in  1  memory completes request; imem_rdata valid this cycle
- imem_rdata  in  DATA_W  instruction word
- inst_valid  out  1  queue head valid
- inst_data  out  DATA_W  queue head instruction
- inst_pc  out  ADDR_W  queue head PC
- inst_ready  in  1  decode consumes head when inst_valid=1
- fault  out  1  misaligned-PC fault, held until flush

Behaviour:
- Reset (rst_n=0, async): state IDLE, queue count 0, addr_q 0. All outputs 0: imem_req, imem_addr, pc_ena, inst_valid, inst_data, inst_pc, fault.
- States: IDLE, WAIT (request outstanding), DROP (flushed request awaiting ack), FAULT.
- Outputs:
  - imem_req = (state==WAIT or DROP).
  - imem_addr = addr_q (registered).
  - fault = (state==FAULT).
- IDLE transitions (no flush):
  - If count<2 and pc_in[1:0]==0: addr_q<=pc_in, go to WAIT.
  - If count<2 and pc_in[1:0]!=0: go to FAULT, no request.
  - If count==2: stay IDLE; a same-cycle pop does not enable issue.
- WAIT:
  - imem_ack=1: push {addr_q, imem_rdata}, pc_ena=1 (combinational, this cycle), go to IDLE.
  - imem_ack=0: stay WAIT, pc_ena=0.
  - Push never overflows: issue requires count<2, and at most one request is outstanding.
- Latency and throughput:
  - Zero-wait memory gives 1 instruction per 2 cycles.
  - Fetched word appears on inst_valid the cycle after ack.
- DROP: imem_req held high. On ack, discard data, go to IDLE, pc_ena=0.
- FAULT: no requests, pc_ena=0. Exits only on flush.
- flush=1 (priority over all else):
  - pc_ena=1 this cycle.
  - Queue cleared at the edge; a same-cycle pop is ignored and a same-cycle push is discarded.
  - Next state:
    - WAIT with ack=0: DROP.
    - WAIT with ack=1: IDLE.
    - DROP with ack=0: DROP.
    - DROP with ack=1: IDLE.
    - IDLE or FAULT: IDLE.
  - No new request is issued in the flush cycle.
- Queue:
  - inst_valid = count!=0; head fields come from register storage.
  - Pop when inst_valid and inst_ready.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pointers wrap mod 2.
  - Empty queue outputs: inst_data and inst_pc hold their last value; only inst_valid is meaningful.
- Reset mid-request: imem_req drops immediately. The memory side must tolerate request abandonment on reset.

Decomposition:
- Package if_pkg:
  - State enum (IDLE, WAIT, DROP, FAULT).
  - ADDR_W/DATA_W defaults.
  - Queue entry struct {pc, inst}.
- Sub-module if_queue: 2-entry FIFO with push, pop, clear, count, and head outputs; async active-low reset.
- FSM, address register, and pc_ena logic live in if_fetch.

Test Plan:
1. Zero-wait fetch:
   - Stimulus: reset, pc_in=0x00000000, imem_ack tied to imem_req, rdata=0x20080005, inst_ready=1.
   - Response: imem_req at cycle 1; pc_ena pulse at cycle 1; inst_valid at cycle 2 with inst_pc=0, inst_data=0x20080005; next request addr 0x4.
2. Wait states:
   - Stimulus: ack delayed 3 cycles.
   - Response: imem_req and imem_addr stable for 4 cycles; a single pc_ena pulse, only in the ack cycle.
3. Backpressure:
   - Stimulus: inst_ready=0, zero-wait memory.
   - Response: exactly 2 entries queued (pc 0x0 and 0x4); IDLE with no imem_req.
   - Then inst_ready=1: entries pop in order, and fetch of 0x8 resumes only after count<2.
4. Flush during outstanding request:
   - Stimulus: flush=1 in WAIT with ack=0; ack 2 cycles later with rdata 0xDEADBEEF.
   - Response: pc_ena=1 only in the flush cycle; queue empty; state DROP; 0xDEADBEEF never appears on inst_data; next request uses the new pc_in.
5. Misaligned PC:
   - Stimulus: pc_in=0x00000006.
   - Response: fault=1, no imem_req, pc_ena=0.
   - Then flush with pc_in=0x00000010: fault clears next cycle and a request issues to 0x10.
6. Async reset:
   - Stimulus: rst_n=0 mid-WAIT with queue count 1.
   - Response: imem_req, inst_valid, and fault go to 0 immediately, without waiting for a clock edge; after release, fetch restarts from pc_in.
